// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS link: generator FSM states, PRBS-15 taps,
// the default sync word and a byte-select helper for it.
package prbs_pkg;

  typedef enum logic [1:0] {
    GEN_IDLE    = 2'd0,
    GEN_PATTERN = 2'd1,
    GEN_PRBS    = 2'd2,
    GEN_DONE    = 2'd3
  } gen_state_e;

  // x^15 + x^14 + 1: feedback from state bits 14 and 13
  localparam int unsigned PRBS_TAP_HI = 14;
  localparam int unsigned PRBS_TAP_LO = 13;

  localparam logic [31:0] SYNC_WORD = 32'hAABBCCDD;

  // Index 0 selects the most significant byte, which goes on the wire first.
  function automatic logic [7:0] sync_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/pattern_generator_if.sv
// Byte-stream interface between the pattern generator and its controller.
// The controller (master) issues start/n/hold; the generator (slave) drives the stream.
interface pattern_generator_if;
  logic       start;
  logic [7:0] n;
  logic       hold;
  logic [7:0] out;
  logic       out_valid;
  logic       busy;
  logic       done;

  modport master (
    output start, n, hold,
    input  out, out_valid, busy, done
  );

  modport slave (
    input  start, n, hold,
    output out, out_valid, busy, done
  );
endinterface

// File: rtl/pattern_generator_prbs15.sv
// PRBS-15 (x^15+x^14+1) byte generator: eight LFSR steps per cycle, first
// generated bit lands in prbs_byte[7]. A load presents the seed's byte in the same cycle.
module prbs15_byte_gen
  import prbs_pkg::*;
#(
  parameter logic [14:0] SEED = 15'h7FFF
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        load,
  input  logic        advance,
  input  logic [14:0] seed,
  output logic [7:0]  prbs_byte
);

  logic [14:0] lfsr_q;
  logic [14:0] stage [0:8];

  // On load the chain starts from the seed, so load+advance emits the seed's byte
  assign stage[0] = load ? seed : lfsr_q;

  genvar gi;
  for (gi = 0; gi < 8; gi++) begin : g_step
    logic fb;
    assign fb               = stage[gi][PRBS_TAP_HI] ^ stage[gi][PRBS_TAP_LO];
    assign stage[gi+1]      = {stage[gi][13:0], fb};
    assign prbs_byte[7-gi]  = fb;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      lfsr_q <= SEED;
    end else if (advance) begin
      lfsr_q <= stage[8];
    end else if (load) begin
      lfsr_q <= stage[0];
    end
  end

endmodule

// File: rtl/pattern_generator.sv
// Transmit-side sync/PRBS burst generator: n copies of the 4-byte sync word, then
// optionally PRBS_BYTES PRBS-15 bytes (compiled in with PATTERN_GEN_PRBS_EN).
module pattern_generator
  import prbs_pkg::*;
#(
  parameter logic [31:0] PATTERN    = SYNC_WORD,
  parameter logic [14:0] PRBS_SEED  = 15'h7FFF,
  parameter logic [15:0] PRBS_BYTES = 16'd64
) (
  input  logic                CLK,
  input  logic                RSTn,
  pattern_generator_if.slave  bus
);

  localparam logic [1:0] ST_IDLE    = GEN_IDLE;
  localparam logic [1:0] ST_PATTERN = GEN_PATTERN;
  localparam logic [1:0] ST_PRBS    = GEN_PRBS;
  localparam logic [1:0] ST_DONE    = GEN_DONE;

  logic [1:0] state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] rep_q, rep_d;
  logic [7:0] n_q, n_d;
  logic [7:0] out_q, out_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       enter_tail;

`ifdef PATTERN_GEN_PRBS_EN
  logic [15:0] cnt_q, cnt_d;
  logic        prbs_load;
  logic        prbs_advance;
  logic [7:0]  prbs_byte;

  // Kept outside the FSM block so the generator's byte never loops back through it
  assign prbs_load = (state_q == ST_IDLE) && bus.start;

  prbs15_byte_gen #(
    .SEED (PRBS_SEED)
  ) u_prbs (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .load      (prbs_load),
    .advance   (prbs_advance),
    .seed      (PRBS_SEED),
    .prbs_byte (prbs_byte)
  );
`else
  wire unused_prbs_cfg = ^{PRBS_SEED, PRBS_BYTES};
`endif

  // Registers describe the byte currently on the wire; each unheld edge produces the next one.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rep_d      = rep_q;
    n_d        = n_q;
    out_d      = out_q;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    enter_tail = 1'b0;
`ifdef PATTERN_GEN_PRBS_EN
    cnt_d        = cnt_q;
    prbs_advance = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          n_d   = bus.n;
          rep_d = 8'd1;
          idx_d = 2'd0;
`ifdef PATTERN_GEN_PRBS_EN
          cnt_d = 16'd0;
`endif
          if (bus.n != 8'd0) begin
            state_d = ST_PATTERN;
            out_d   = sync_byte(PATTERN, 2'd0);
            valid_d = 1'b1;
          end else begin
            enter_tail = 1'b1;
          end
        end
      end

      ST_PATTERN: begin
        if (!bus.hold) begin
          if (idx_q == 2'd3) begin
            if (rep_q == n_q) begin
              enter_tail = 1'b1;
            end else begin
              rep_d   = rep_q + 8'd1;
              idx_d   = 2'd0;
              out_d   = sync_byte(PATTERN, 2'd0);
              valid_d = 1'b1;
            end
          end else begin
            idx_d   = idx_q + 2'd1;
            out_d   = sync_byte(PATTERN, idx_q + 2'd1);
            valid_d = 1'b1;
          end
        end
      end

`ifdef PATTERN_GEN_PRBS_EN
      ST_PRBS: begin
        if (!bus.hold) begin
          if (cnt_q == PRBS_BYTES) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            out_d        = prbs_byte;
            valid_d      = 1'b1;
            prbs_advance = 1'b1;
            cnt_d        = cnt_q + 16'd1;
          end
        end
      end
`endif

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    // Pattern phase finished (or skipped): PRBS payload if present, else straight to DONE
    if (enter_tail) begin
`ifdef PATTERN_GEN_PRBS_EN
      if (PRBS_BYTES == 16'd0) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end else begin
        state_d      = ST_PRBS;
        out_d        = prbs_byte;
        valid_d      = 1'b1;
        prbs_advance = 1'b1;
        cnt_d        = 16'd1;
      end
`else
      state_d = ST_DONE;
      done_d  = 1'b1;
`endif
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      rep_q   <= 8'd0;
      n_q     <= 8'd0;
      out_q   <= 8'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef PATTERN_GEN_PRBS_EN
      cnt_q   <= 16'd0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      n_q     <= n_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef PATTERN_GEN_PRBS_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule
